// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: control-bundle pipeline from decode (stage 0) through
// STAGES-1 registered stages. Each stage has a valid bit, a stall and a
// flush. A stage behind a stall inserts bubbles. A multi-cycle execute hold
// keeps a long-latency op in stage 1 and back-pressures decode.
//
// Build option CTRL_PIPE_MC_EN:
//   defined   -> the multi-cycle counter, mc_busy and mc_done are built.
//   undefined -> mc_d is ignored, mc_busy/mc_done are tied 0 and every
//                bundle moves as a single-cycle op.
//
// Reset is asynchronous and active-low on rst.

module ctrl_pipe_chain #(
    parameter int CTRL_W = 12,
    parameter int STAGES = 4,
    parameter int MC_LAT = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CTRL_W-1:0]              ctrl_d,
    input  logic                           valid_d,
    input  logic                           mc_d,
    input  logic [STAGES-2:0]              stall_i,
    input  logic [STAGES-2:0]              flush_i,
    output logic [(STAGES-1)*CTRL_W-1:0]   ctrl_q,
    output logic [STAGES-2:0]              valid_q,
    output logic                           accept_d,
    output logic                           mc_busy,
    output logic                           mc_done
);

    // Number of registered stages (1..NR).
    localparam int NR = STAGES - 1;

    // hold[k] : stage k keeps its contents this edge. hold[0] is always 0 so
    // stage 1 never sees a "previous stage held" condition from decode.
    logic [NR:0]       hold;
    logic              mc_busy_int;

    // Per-stage view used to chain the stages: index 0 is decode, index k
    // is the registered content of stage k.
    logic [CTRL_W-1:0] stage_ctrl  [0:NR];
    logic              stage_valid [0:NR];

    // Decode feeds stage 1; an invalid decode slot always carries ctrl 0 so
    // it can never cause a write or a branch further down the pipe.
    assign stage_ctrl[0]  = valid_d ? ctrl_d : '0;
    assign stage_valid[0] = valid_d;

    // Effective hold: a stall on stage j also holds every stage below it,
    // and the multi-cycle op additionally holds stage 1.
    always_comb begin
        logic stall_acc;
        stall_acc = 1'b0;
        hold      = '0;
        for (int k = NR; k >= 1; k--) begin
            stall_acc = stall_acc | stall_i[k-1];
            hold[k]   = stall_acc;
        end
        hold[1] = hold[1] | mc_busy_int;
    end

    // Decode may only advance when stage 1 is free to load it.
    assign accept_d = ~hold[1];

    genvar gi;
    generate
        for (gi = 1; gi <= NR; gi++) begin : g_stage
            logic [CTRL_W-1:0] stg_ctrl_q;
            logic [CTRL_W-1:0] stg_ctrl_d;
            logic              stg_valid_q;
            logic              stg_valid_d;

            // Next contents: flush beats hold, hold beats bubble, bubble
            // beats the normal advance from the stage in front.
            always_comb begin
                stg_ctrl_d  = stg_ctrl_q;
                stg_valid_d = stg_valid_q;
                if (flush_i[gi-1]) begin
                    stg_ctrl_d  = '0;
                    stg_valid_d = 1'b0;
                end else if (hold[gi]) begin
                    stg_ctrl_d  = stg_ctrl_q;
                    stg_valid_d = stg_valid_q;
                end else if (hold[gi-1]) begin
                    stg_ctrl_d  = '0;
                    stg_valid_d = 1'b0;
                end else begin
                    stg_ctrl_d  = stage_ctrl[gi-1];
                    stg_valid_d = stage_valid[gi-1];
                end
            end

            // Stage register with asynchronous clear.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stg_ctrl_q  <= '0;
                    stg_valid_q <= 1'b0;
                end else begin
                    stg_ctrl_q  <= stg_ctrl_d;
                    stg_valid_q <= stg_valid_d;
                end
            end

            assign stage_ctrl[gi]                     = stg_ctrl_q;
            assign stage_valid[gi]                    = stg_valid_q;
            assign ctrl_q[(gi-1)*CTRL_W +: CTRL_W]    = stg_ctrl_q;
            assign valid_q[gi-1]                      = stg_valid_q;
        end
    endgenerate

    // Stage NR's view is only consumed through the output ports.
    logic unused_last_stage;
    assign unused_last_stage = stage_valid[NR] & (|stage_ctrl[NR]);

`ifdef CTRL_PIPE_MC_EN
    localparam int CNT_W = $clog2(MC_LAT + 1);

    logic [CNT_W-1:0] mc_cnt_q;
    logic [CNT_W-1:0] mc_cnt_d;
    logic             mc_load;
    logic             mc_dec;

    // A multi-cycle op is captured when stage 1 really takes it from decode.
    // The counter steps only when no stall reaches stage 1.
    always_comb begin
        mc_load  = valid_d & mc_d & ~hold[1] & ~flush_i[0];
        mc_dec   = (mc_cnt_q != '0) & ~(|stall_i);
        mc_cnt_d = mc_cnt_q;
        if (flush_i[0]) begin
            mc_cnt_d = '0;
        end else if (mc_dec) begin
            mc_cnt_d = mc_cnt_q - CNT_W'(1);
        end else if (mc_load) begin
            mc_cnt_d = CNT_W'(MC_LAT - 1);
        end
    end

    // Remaining hold cycles for the op sitting in stage 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_cnt_q <= '0;
        end else begin
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign mc_busy_int = (mc_cnt_q != '0);
    assign mc_busy     = mc_busy_int;
    // With MC_LAT==1 there is no hold, so the pulse marks the load itself.
    assign mc_done     = ((mc_cnt_q == CNT_W'(1)) & mc_dec) |
                         ((MC_LAT == 1) & mc_load);
`else
    assign mc_busy_int = 1'b0;
    assign mc_busy     = 1'b0;
    assign mc_done     = 1'b0;

    // mc_d and MC_LAT have no effect without the multi-cycle hold.
    logic unused_mc_cfg;
    assign unused_mc_cfg = mc_d & (MC_LAT > 0);
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Scoreboard bench for ctrl_pipe_chain. The driver computes the expected
// outputs of each cycle from a stage-list model and queues them; a monitor
// on the falling edge pops and compares against the DUT.

module tb_ctrl_pipe_chain;

    localparam int W   = 12;
    localparam int S   = 4;
    localparam int NR  = S - 1;
    localparam int LAT = 4;
`ifdef CTRL_PIPE_MC_EN
    localparam bit MC_EN = 1'b1;
`else
    localparam bit MC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [W-1:0]      ctrl_d;
    logic              valid_d;
    logic              mc_d;
    logic [NR-1:0]     stall_i;
    logic [NR-1:0]     flush_i;
    logic [NR*W-1:0]   ctrl_q;
    logic [NR-1:0]     valid_q;
    logic              accept_d;
    logic              mc_busy;
    logic              mc_done;

    ctrl_pipe_chain #(.CTRL_W(W), .STAGES(S), .MC_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl_d   (ctrl_d),
        .valid_d  (valid_d),
        .mc_d     (mc_d),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .ctrl_q   (ctrl_q),
        .valid_q  (valid_q),
        .accept_d (accept_d),
        .mc_busy  (mc_busy),
        .mc_done  (mc_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0]   v;
        logic [NR*W-1:0] c;
        logic            acc;
        logic            busy;
        logic            done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Model: list of stage contents plus the progress of a multi-cycle op.
    logic [W-1:0] m_ctrl  [1:NR];
    bit           m_valid [1:NR];
    bit           mc_pending;
    int           mc_served;

    task automatic model_clear();
        for (int k = 1; k <= NR; k++) begin
            m_ctrl[k]  = '0;
            m_valid[k] = 1'b0;
        end
        mc_pending = 1'b0;
        mc_served  = 0;
    endtask

    // Drive one cycle of inputs, queue the expected outputs, advance model.
    task automatic cycle(input bit r, input bit v, input logic [W-1:0] c,
                         input bit m, input logic [NR-1:0] s,
                         input logic [NR-1:0] f);
        int           h;
        int           heff;
        bit           busy;
        bit           stall1;
        bit           acc;
        bit           load;
        bit           done;
        exp_t         e;
        logic [W-1:0] nc [1:NR];
        bit           nv [1:NR];
        logic [W-1:0] in_c;

        in_c    = v ? c : '0;
        rst     = r;
        valid_d = v;
        ctrl_d  = in_c;
        mc_d    = m;
        stall_i = s;
        flush_i = f;
        if (!r) model_clear();

        // Highest stalled stage: it and everything below it are held.
        h = 0;
        for (int k = 1; k <= NR; k++) if (s[k-1]) h = k;
        stall1 = (h >= 1);
        busy   = MC_EN && mc_pending && (mc_served < LAT - 1);
        heff   = (h == 0 && busy) ? 1 : h;
        acc    = (heff == 0);
        load   = MC_EN && acc && !f[0] && v && m;
        done   = (busy && !stall1 && (mc_served == LAT - 2)) || (load && LAT == 1);

        for (int k = 1; k <= NR; k++) begin
            e.v[k-1]         = m_valid[k];
            e.c[(k-1)*W +: W] = m_ctrl[k];
        end
        e.acc  = acc;
        e.busy = busy;
        e.done = done;
        exp_q.push_back(e);

        if (r) begin
            for (int k = 1; k <= NR; k++) begin
                if (f[k-1]) begin
                    nc[k] = '0; nv[k] = 1'b0;
                end else if (k <= heff) begin
                    nc[k] = m_ctrl[k]; nv[k] = m_valid[k];
                end else if (k == heff + 1 && heff >= 1) begin
                    nc[k] = '0; nv[k] = 1'b0;
                end else if (k == 1) begin
                    nc[k] = in_c; nv[k] = v;
                end else begin
                    nc[k] = m_ctrl[k-1]; nv[k] = m_valid[k-1];
                end
            end
            for (int k = 1; k <= NR; k++) begin
                m_ctrl[k]  = nc[k];
                m_valid[k] = nv[k];
            end
            if (f[0]) begin
                mc_pending = 1'b0;
                mc_served  = 0;
            end else if (busy) begin
                if (!stall1) mc_served = mc_served + 1;
            end else begin
                mc_pending = load && (LAT > 1);
                mc_served  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, '0, 0, '0, '0);
    endtask

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // Monitor: one comparison set per cycle, sampled mid-cycle.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                cyc++;
                $display("cyc %0d rst=%b v=%b c=%h acc=%b busy=%b done=%b",
                         cyc, rst, valid_q, ctrl_q, accept_d, mc_busy, mc_done);
                check("valid_q",  64'(valid_q),  64'(mon_e.v));
                check("ctrl_q",   64'(ctrl_q),   64'(mon_e.c));
                check("accept_d", 64'(accept_d), 64'(mon_e.acc));
                check("mc_busy",  64'(mc_busy),  64'(mon_e.busy));
                check("mc_done",  64'(mc_done),  64'(mon_e.done));
            end
        end
    end

    initial begin
        rst     = 1'b0;
        valid_d = 1'b0;
        ctrl_d  = '0;
        mc_d    = 1'b0;
        stall_i = '0;
        flush_i = '0;
        model_clear();
        @(posedge clk);
        #1;

        // Reset held, then released
        cycle(0, 0, '0, 0, '0, '0);
        cycle(0, 0, '0, 0, 3'b010, '0);

        // Streaming 0x001..0x005
        for (int i = 1; i <= 5; i++) cycle(1, 1, W'(i), 0, '0, '0);
        idle(4);

        // Flush of stage 1 holding 0x0A5
        cycle(1, 1, W'(12'h0A5), 0, '0, '0);
        cycle(1, 0, '0, 0, '0, 3'b001);
        idle(3);

        // Stall on stage 2 with A, B, C in stages 1, 2, 3
        cycle(1, 1, W'(12'h00C), 0, '0, '0);
        cycle(1, 1, W'(12'h00B), 0, '0, '0);
        cycle(1, 1, W'(12'h00A), 0, '0, '0);
        cycle(1, 1, W'(12'h00D), 0, 3'b010, '0);
        cycle(1, 1, W'(12'h00D), 0, 3'b010, '0);
        cycle(1, 1, W'(12'h00D), 0, '0, '0);
        idle(3);

        // Flush and stall together on stage 2
        cycle(1, 1, W'(12'h0E1), 0, '0, '0);
        cycle(1, 1, W'(12'h0E2), 0, '0, '0);
        cycle(1, 1, W'(12'h0E3), 0, 3'b010, 3'b010);
        idle(3);

        // Multi-cycle op 0x0FF, decode keeps offering 0x100
        cycle(1, 1, W'(12'h0FF), 1, '0, '0);
        for (int i = 0; i < 5; i++) cycle(1, 1, W'(12'h100), 0, '0, '0);
        idle(4);

        // Multi-cycle op extended by a stall
        cycle(1, 1, W'(12'h0FF), 1, '0, '0);
        cycle(1, 1, W'(12'h101), 0, 3'b001, '0);
        idle(6);

        // Reset during the second busy cycle, then stream again
        cycle(1, 1, W'(12'h0FF), 1, '0, '0);
        cycle(1, 0, '0, 0, '0, '0);
        cycle(0, 0, '0, 0, '0, '0);
        cycle(0, 0, '0, 0, '0, '0);
        for (int i = 1; i <= 3; i++) cycle(1, 1, W'(12'h010 + i), 0, '0, '0);
        idle(4);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [NR-1:0] s;
            logic [NR-1:0] f;
            for (int k = 0; k < NR; k++) begin
                s[k] = ($urandom_range(0, 5) == 0);
                f[k] = ($urandom_range(0, 9) == 0);
            end
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) != 0),
                  W'($urandom),
                  ($urandom_range(0, 5) == 0),
                  s, f);
        end
        idle(2);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
